// File: rtl/alu_arb_pkg.sv
// Shared constants and elaboration helpers for the ALU arbiter slice.
package alu_arb_pkg;

   localparam int DATA_W  = 16;
   localparam int COM_W   = 3;
   localparam int MAX_REQ = 8;

   function automatic int clog2(input int unsigned n);
      int r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/alu.sv
// Existing combinational 16-bit ALU; opcodes follow def.h
// (THA=0, THB=1, AND=2, OR=3, SL=4, SR=5, ADD=6, SUB=7).
module alu (
   input  logic [15:0] ina,
   input  logic [15:0] inb,
   input  logic [2:0]  com,
   output logic [15:0] out
);

   always_comb begin
      out = '0;
      case (com)
         3'd0: out = ina;
         3'd1: out = inb;
         3'd2: out = ina & inb;
         3'd3: out = ina | inb;
         3'd4: out = ina << inb;
         3'd5: out = ina >> inb;
         3'd6: out = ina + inb;
         3'd7: out = ina - inb;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker; `define ALU_ARB_FIXED_PRIO_EN selects
// fixed lowest-index priority instead.
module alu_rr_pick
   import alu_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx
);

   logic        found;
   int unsigned j;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = k;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
`else
      // Search starts one past the last grant and wraps; k = N_REQ revisits ptr itself.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         j = (32'(ptr) + k) % N_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
`endif
      if (!en) grant = '0;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ valid/ready requesters with a registered, id-tagged
// response. Optional macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [DATA_W*N_REQ-1:0]   req_ina,
   input  logic [DATA_W*N_REQ-1:0]   req_inb,
   input  logic [COM_W*N_REQ-1:0]    req_com,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data
);

   if (N_REQ < 2 || N_REQ > MAX_REQ || ID_W < clog2(N_REQ)) begin : g_param_err
      $error("alu_arbiter: illegal N_REQ/ID_W combination");
   end

   logic              can_accept;
   logic              xfer;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   idx;
   logic [ID_W-1:0]   ptr;
   logic [DATA_W-1:0] sel_ina;
   logic [DATA_W-1:0] sel_inb;
   logic [COM_W-1:0]  sel_com;
   logic [DATA_W-1:0] alu_y;

   assign can_accept = ~rsp_valid | rsp_ready;

   // rst_n in the enable keeps req_ready low throughout reset.
   alu_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (can_accept & rst_n),
      .grant (grant),
      .idx   (idx)
   );

   assign req_ready = grant;
   assign xfer      = |grant;

   assign sel_ina = req_ina[idx*DATA_W +: DATA_W];
   assign sel_inb = req_inb[idx*DATA_W +: DATA_W];
   assign sel_com = req_com[idx*COM_W +: COM_W];

   alu u_alu (
      .ina (sel_ina),
      .inb (sel_inb),
      .com (sel_com),
      .out (alu_y)
   );

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ptr <= ID_W'(N_REQ - 1);
      else if (xfer) ptr <= idx;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (xfer) begin
         rsp_valid <= 1'b1;
         rsp_id    <= idx;
         rsp_data  <= alu_y;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (N_REQ=2); define ALU_ARB_FIXED_PRIO_EN for the fixed-priority build.
module tb_alu_arbiter;

   localparam logic [2:0] THB = 3'd1, SL = 3'd4, SR = 3'd5, ADD = 3'd6, SUB = 3'd7;

   typedef struct packed {
      logic [2:0]  id;
      logic [15:0] data;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_ina;
   logic [31:0] req_inb;
   logic [5:0]  req_com;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_id;
   logic [15:0] rsp_data;

   int   checks = 0;
   int   errors = 0;
   rsp_t q[$];

   alu_arbiter #(.N_REQ(2), .ID_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ina   (req_ina),
      .req_inb   (req_inb),
      .req_com   (req_com),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
      req_ina[i*16 +: 16] = a;
      req_inb[i*16 +: 16] = b;
      req_com[i*3 +: 3]   = c;
   endtask

   // One cycle: drive at negedge, check req_ready, queue the expected response.
   task automatic step(input logic [1:0] v, input logic rr, input logic [1:0] er, input logic [15:0] ed);
      rsp_t e;
      @(negedge clk);
      req_valid = v;
      rsp_ready = rr;
      #1;
      check("req_ready", 32'(req_ready), 32'(er));
      if (er != 2'b00) begin
         e.id   = er[1] ? 3'd1 : 3'd0;
         e.data = ed;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
               e = q.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(e.id));
               check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
         end
      end
   end

   initial begin : stim
      rst_n     = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      req_ina   = '0;
      req_inb   = '0;
      req_com   = '0;
      #12;
      check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      check("reset_rsp_id", 32'(rsp_id), 32'(0));
      check("reset_rsp_data", 32'(rsp_data), 32'(0));
      check("reset_req_ready", 32'(req_ready), 32'(0));
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single requester ADD
      set_op(0, 16'h0003, 16'h0004, ADD);
      step(2'b01, 1'b1, 2'b01, 16'h0007);
      step(2'b00, 1'b1, 2'b00, 16'h0000);

      set_op(0, 16'h0010, 16'h0001, SUB);
      set_op(1, 16'h0001, 16'h0004, SL);
`ifdef ALU_ARB_FIXED_PRIO_EN
      // req0 always wins while valid; req1 gets in once req0 drops
      repeat (4) step(2'b11, 1'b1, 2'b01, 16'h000F);
      step(2'b10, 1'b1, 2'b10, 16'h0010);
      step(2'b00, 1'b1, 2'b00, 16'h0000);
`else
      // alternation; pointer is 0 after the first transfer
      step(2'b11, 1'b1, 2'b10, 16'h0010);
      step(2'b11, 1'b1, 2'b01, 16'h000F);
      step(2'b11, 1'b1, 2'b10, 16'h0010);
      step(2'b11, 1'b1, 2'b01, 16'h000F);

      // stall with id1 pending: nothing accepted, response held
      step(2'b11, 1'b1, 2'b10, 16'h0010);
      repeat (3) begin
         step(2'b11, 1'b0, 2'b00, 16'h0000);
         check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
         check("stall_rsp_id", 32'(rsp_id), 32'(1));
         check("stall_rsp_data", 32'(rsp_data), 32'h0010);
      end
      step(2'b11, 1'b1, 2'b01, 16'h000F);
      step(2'b00, 1'b1, 2'b00, 16'h0000);

      // async reset mid-cycle drops the pending response and restores priority
      step(2'b01, 1'b1, 2'b01, 16'h000F);
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rsp_valid", 32'(rsp_valid), 32'(0));
      check("async_rsp_data", 32'(rsp_data), 32'(0));
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(2'b11, 1'b1, 2'b01, 16'h000F);
      step(2'b11, 1'b1, 2'b10, 16'h0010);
      step(2'b00, 1'b1, 2'b00, 16'h0000);
`endif

      // edge arithmetic
      set_op(0, 16'h8000, 16'd16, SR);
      step(2'b01, 1'b1, 2'b01, 16'h0000);
      set_op(0, 16'hFFFF, 16'h0001, ADD);
      step(2'b01, 1'b1, 2'b01, 16'h0000);
      set_op(0, 16'h1234, 16'hA5A5, THB);
      step(2'b01, 1'b1, 2'b01, 16'hA5A5);
      set_op(1, 16'h0000, 16'h0001, SUB);
      step(2'b10, 1'b1, 2'b10, 16'hFFFF);
      step(2'b00, 1'b1, 2'b00, 16'h0000);
      step(2'b00, 1'b1, 2'b00, 16'h0000);

      check("queue_empty", 32'(q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
